// File: rtl/ce_strobe_pkg.sv
// Shared state encoding and default widths for the CE/CLR strobe generator.
package ce_strobe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        FIN
    } state_t;

    localparam int DIV_W_DEF  = 8;
    localparam int CNT_W_DEF  = 8;
    localparam int CONTINUOUS = 0;

endpackage

// File: rtl/ce_div_counter.sv
// Reloadable down-counter that paces SP strobes; load beats enable.
module ce_div_counter
    import ce_strobe_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_val,
    output logic             o_zero
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ce_strobe_gen.sv
// Clock-enable / sync-clear strobe generator for enable/clear flop banks.
// CE_STROBE_SYNC_IN_EN adds 2-flop sync + edge detect on START/STOP.
module ce_strobe_gen
    import ce_strobe_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             START,
    input  logic             STOP,
    input  logic [DIV_W-1:0] DIV,
    input  logic [CNT_W-1:0] BURST_LEN,
    output logic             SP,
    output logic             CLR,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] STROBE_CNT
);

    state_t           r_state;
    state_t           w_next;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_burst;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_sp;
    logic             r_clr;
    logic             r_busy;
    logic             r_done;
    logic             w_start;
    logic             w_stop;
    logic             w_zero;
    logic             w_sp;
    logic             w_accept;

`ifdef CE_STROBE_SYNC_IN_EN
    logic [2:0] r_start_sync;
    logic [2:0] r_stop_sync;
    logic       r_start_p;
    logic       r_stop_p;

    always_ff @(posedge CK) begin
        if (CD) begin
            r_start_sync <= '0;
            r_stop_sync  <= '0;
            r_start_p    <= 1'b0;
            r_stop_p     <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[1:0], START};
            r_stop_sync  <= {r_stop_sync[1:0], STOP};
            r_start_p    <= r_start_sync[1] & ~r_start_sync[2];
            r_stop_p     <= r_stop_sync[1] & ~r_stop_sync[2];
        end
    end

    assign w_start = r_start_p;
    assign w_stop  = r_stop_p;
`else
    assign w_start = START;
    assign w_stop  = STOP;
`endif

    ce_div_counter #(
        .DIV_W (DIV_W)
    ) u_div (
        .i_clk  (CK),
        .i_rst  (CD),
        .i_load ((r_state == CLEAR) || ((r_state == RUN) && w_zero)),
        .i_en   (r_state == RUN),
        .i_val  (r_div),
        .o_zero (w_zero)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_accept  = (r_state == IDLE) && w_start;

    // STOP outranks a strobe that falls due in the same cycle.
    always_comb begin
        w_next = r_state;
        w_sp   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) w_next = CLEAR;
            end
            CLEAR: begin
                w_next = RUN;
            end
            RUN: begin
                if (w_stop) begin
                    w_next = FIN;
                end else if (w_zero) begin
                    w_sp = 1'b1;
                    if ((r_burst != CNT_W'(CONTINUOUS)) &&
                        (w_cnt_inc == r_burst)) begin
                        w_next = FIN;
                    end
                end
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (CD) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_sp    <= 1'b0;
            r_clr   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sp    <= w_sp;
            r_clr   <= (r_state == CLEAR);
            r_busy  <= (r_state == CLEAR) || (r_state == RUN);
            r_done  <= (r_state == FIN);
            if (w_accept) begin
                r_div   <= DIV;
                r_burst <= BURST_LEN;
            end
            if (r_state == CLEAR) begin
                r_cnt <= '0;
            end else if (w_sp) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign SP         = r_sp;
    assign CLR        = r_clr;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign STROBE_CNT = r_cnt;

endmodule
